// File: rtl/fp_pkg.sv
// Shared types and constants for the single-precision normalize/round datapath.
// Imported by the rounding sub-module and the stage top level.
package fp_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int GRS_W  = 3;
    localparam int MANT_W = FRAC_W + 1 + GRS_W;
    localparam int BIAS   = 127;

    localparam logic [EXP_W:0] EXP_MAX = 9'd255;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        ROUND,
        DONE
    } state_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

endpackage

// File: rtl/fp_rne_round.sv
// Round-to-nearest-even on a normalized (or subnormal) 27-bit mantissa,
// packing the binary32 result with overflow and inexact flags.
module fp_rne_round
    import fp_pkg::*;
(
    input  logic              sign,
    input  logic [MANT_W-1:0] mant,
    input  logic [EXP_W:0]    exp,
    input  logic              subnormal,
    output fp32_t             result,
    output logic              overflow,
    output logic              inexact
);

    logic              up;
    logic [FRAC_W+1:0] sum;
    logic [EXP_W:0]    exp_r;
    logic [FRAC_W-1:0] frac;
    logic [EXP_W-1:0]  field;

    always_comb begin
        up    = mant[2] & (mant[3] | mant[1] | mant[0]);
        sum   = {1'b0, mant[MANT_W-1:GRS_W]} + {{(FRAC_W+1){1'b0}}, up};
        exp_r = exp + {{EXP_W{1'b0}}, sum[FRAC_W+1]};
        frac  = sum[FRAC_W+1] ? '0 : sum[FRAC_W-1:0];
        // A subnormal that rounds into bit 23 becomes the minimum normal
        if (subnormal && !sum[FRAC_W+1] && !sum[FRAC_W])
            field = '0;
        else
            field = exp_r[EXP_W-1:0];
        overflow = (exp_r >= EXP_MAX);
        if (overflow) begin
            result.sign = sign;
            result.exp  = '1;
            result.frac = '0;
        end else begin
            result.sign = sign;
            result.exp  = field;
            result.frac = frac;
        end
        inexact = (|mant[GRS_W-1:0]) | overflow;
    end

endmodule

// File: rtl/fp_normalize_round.sv
// Post-add normalize-and-round stage: one left shift per cycle, then RNE,
// result held under a valid/ready handshake.
module fp_normalize_round
    import fp_pkg::*;
(
    input  logic              clk,
    input  logic              n_rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic              in_carry,
    input  logic [MANT_W-1:0] in_mant,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_result,
    output logic              out_overflow,
    output logic              out_inexact
);

    state_t            state, state_n;
    logic              sign, sign_n;
    logic [EXP_W:0]    exp, exp_n;
    logic [MANT_W-1:0] mant, mant_n;
    logic [MANT_W-1:0] shifted;
    logic              sub, sub_n;
    fp32_t             res, res_n;
    logic              ovf, ovf_n;
    logic              inx, inx_n;

    fp32_t             rnd_result;
    logic              rnd_overflow;
    logic              rnd_inexact;

    fp_rne_round u_round (
        .sign      (sign),
        .mant      (mant),
        .exp       (exp),
        .subnormal (sub),
        .result    (rnd_result),
        .overflow  (rnd_overflow),
        .inexact   (rnd_inexact)
    );

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state <= IDLE;
            sign  <= 1'b0;
            exp   <= '0;
            mant  <= '0;
            sub   <= 1'b0;
            res   <= '0;
            ovf   <= 1'b0;
            inx   <= 1'b0;
        end else begin
            state <= state_n;
            sign  <= sign_n;
            exp   <= exp_n;
            mant  <= mant_n;
            sub   <= sub_n;
            res   <= res_n;
            ovf   <= ovf_n;
            inx   <= inx_n;
        end
    end

    always_comb begin
        state_n = state;
        sign_n  = sign;
        exp_n   = exp;
        mant_n  = mant;
        sub_n   = sub;
        res_n   = res;
        ovf_n   = ovf;
        inx_n   = inx;
        shifted = {mant[MANT_W-2:0], 1'b0};
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    sign_n = in_sign;
                    sub_n  = 1'b0;
                    exp_n  = {1'b0, in_exp};
                    mant_n = in_mant;
                    if (in_carry) begin
                        mant_n  = {1'b1, in_mant[MANT_W-1:2], |in_mant[1:0]};
                        exp_n   = {1'b0, in_exp} + 9'd1;
                        state_n = ROUND;
                    end else if (in_mant == '0) begin
                        res_n.sign = in_sign;
                        res_n.exp  = '0;
                        res_n.frac = '0;
                        ovf_n   = 1'b0;
                        inx_n   = 1'b0;
                        state_n = DONE;
                    end else if (in_mant[MANT_W-1]) begin
                        state_n = ROUND;
                    end else begin
                        state_n = NORM;
                    end
                end
            end
            NORM: begin
                if (mant[MANT_W-1]) begin
                    state_n = ROUND;
                end else if (exp == 9'd1) begin
                    sub_n   = 1'b1;
                    state_n = ROUND;
                end else begin
                    // Leave as soon as the shift lands the hidden bit
                    mant_n = shifted;
                    exp_n  = exp - 9'd1;
                    if (shifted[MANT_W-1])
                        state_n = ROUND;
                end
            end
            ROUND: begin
                res_n   = rnd_result;
                ovf_n   = rnd_overflow;
                inx_n   = rnd_inexact;
                state_n = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign in_ready     = (state == IDLE);
    assign out_valid    = (state == DONE);
    assign out_result   = res;
    assign out_overflow = ovf;
    assign out_inexact  = inx;

endmodule

// File: tb/tb_fp_normalize_round.sv
// Directed-vector bench for fp_normalize_round: result, flags, latency,
// backpressure and mid-operation reset.
module tb_fp_normalize_round;

    logic        clk;
    logic        n_rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic        in_carry;
    logic [26:0] in_mant;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_overflow;
    logic        out_inexact;

    int n_cmp;
    int n_fail;

    typedef struct {
        string       name;
        logic        sign;
        logic [7:0]  exp;
        logic        carry;
        logic [26:0] mant;
        logic [31:0] result;
        logic        ovf;
        logic        inx;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    fp_normalize_round dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sign      (in_sign),
        .in_exp       (in_exp),
        .in_carry     (in_carry),
        .in_mant      (in_mant),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_overflow (out_overflow),
        .out_inexact  (out_inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp_v);
        end
    endtask

    task automatic accept(input logic s, input logic [7:0] e,
                          input logic c, input logic [26:0] m);
        @(negedge clk);
        in_sign  = s;
        in_exp   = e;
        in_carry = c;
        in_mant  = m;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic handshake(input string name);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({name, ".idle_ready"}, {31'b0, in_ready}, 32'd1);
        chk({name, ".idle_valid"}, {31'b0, out_valid}, 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        @(negedge clk);
        chk({v.name, ".in_ready"}, {31'b0, in_ready}, 32'd1);
        accept(v.sign, v.exp, v.carry, v.mant);
        wait_valid(lat);
        chk({v.name, ".latency"}, lat, v.lat);
        chk({v.name, ".result"}, out_result, v.result);
        chk({v.name, ".overflow"}, {31'b0, out_overflow}, {31'b0, v.ovf});
        chk({v.name, ".inexact"}, {31'b0, out_inexact}, {31'b0, v.inx});
        handshake(v.name);
    endtask

    initial begin
        int lat;
        n_cmp     = 0;
        n_fail    = 0;
        n_rst     = 1'b0;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_carry  = 1'b0;
        in_mant   = '0;
        out_ready = 1'b0;

        vecs[0]  = '{"one_plus_one", 0, 127, 1, 27'h0000000, 32'h40000000, 0, 0, 2};
        vecs[1]  = '{"norm23",       0, 127, 0, 27'h0000008, 32'h34000000, 0, 0, 25};
        vecs[2]  = '{"tie_even",     0, 127, 0, 27'h4000004, 32'h3F800000, 0, 1, 2};
        vecs[3]  = '{"tie_odd",      0, 127, 0, 27'h400000C, 32'h3F800002, 0, 1, 2};
        vecs[4]  = '{"round_carry",  0, 127, 0, 27'h7FFFFFC, 32'h40000000, 0, 1, 2};
        vecs[5]  = '{"carry_ovf",    0, 254, 1, 27'h0000000, 32'h7F800000, 1, 1, 2};
        vecs[6]  = '{"neg_zero",     1, 100, 0, 27'h0000000, 32'h80000000, 0, 0, 1};
        vecs[7]  = '{"subnormal",    0, 1,   0, 27'h2000000, 32'h00400000, 0, 0, 3};
        vecs[8]  = '{"norm26",       0, 127, 0, 27'h0000001, 32'h32800000, 0, 0, 28};
        vecs[9]  = '{"carry_sticky", 1, 127, 1, 27'h0000003, 32'hC0000000, 0, 1, 2};
        vecs[10] = '{"carry_round",  0, 127, 1, 27'h000000C, 32'h40000001, 0, 1, 2};
        vecs[11] = '{"sub_to_norm",  0, 1,   0, 27'h3FFFFFC, 32'h00800000, 0, 1, 3};
        vecs[12] = '{"round_ovf",    0, 254, 0, 27'h7FFFFFC, 32'h7F800000, 1, 1, 2};
        vecs[13] = '{"norm_to_sub",  0, 2,   0, 27'h0800000, 32'h00200000, 0, 0, 4};
        vecs[14] = '{"pos_zero",     0, 5,   0, 27'h0000000, 32'h00000000, 0, 0, 1};
        vecs[15] = '{"norm1",        1, 130, 0, 27'h3000000, 32'hC0C00000, 0, 0, 3};

        repeat (2) @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        #1;
        chk("reset.in_ready", {31'b0, in_ready}, 32'd1);
        chk("reset.out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset.result", out_result, 32'h0);
        chk("reset.flags", {30'b0, out_overflow, out_inexact}, 32'd0);

        for (int i = 0; i < 16; i++)
            run_vec(vecs[i]);

        // Backpressure: result held while out_ready is low
        accept(0, 127, 0, 27'h400000C);
        wait_valid(lat);
        chk("bp.latency", lat, 2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_mant  = 27'h0000001;
            @(posedge clk);
            #1;
            chk("bp.result", out_result, 32'h3F800002);
            chk("bp.valid", {31'b0, out_valid}, 32'd1);
            chk("bp.in_ready", {31'b0, in_ready}, 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        handshake("bp");

        // Reset in the middle of a long normalization
        accept(0, 127, 0, 27'h0000001);
        repeat (5) @(posedge clk);
        @(negedge clk);
        n_rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst.out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst.in_ready", {31'b0, in_ready}, 32'd1);
        chk("midrst.result", out_result, 32'h0);
        @(negedge clk);
        n_rst = 1'b1;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                chk("midrst.spurious_valid", {31'b0, out_valid}, 32'd0);
                break;
            end
        end
        run_vec(vecs[3]);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
